// File: rtl/deser400_tp_pkg.sv
// Shared encodings for the deser400 test-point event counter: event qualifier
// modes and measurement FSM states.
package deser400_tp_pkg;

    localparam logic [1:0] TP_RISE = 2'd0;
    localparam logic [1:0] TP_FALL = 2'd1;
    localparam logic [1:0] TP_BOTH = 2'd2;
    localparam logic [1:0] TP_HIGH = 2'd3;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] COUNT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

endpackage

// File: rtl/tp_event_qual.sv
// Turns one test-point sample and its previous-cycle value into a 1-bit event
// strobe according to the selected qualifier mode.
module tp_event_qual
    import deser400_tp_pkg::*;
(
    input  logic       i_sample,
    input  logic       i_prev,
    input  logic [1:0] i_mode,
    output logic       o_event
);

    always_comb begin
        o_event = 1'b0;
        case (i_mode)
            TP_RISE: o_event = i_sample & ~i_prev;
            TP_FALL: o_event = ~i_sample & i_prev;
            TP_BOTH: o_event = i_sample ^ i_prev;
            default: o_event = i_sample;
        endcase
    end

endmodule

// File: rtl/deser400_tp_counter.sv
// Gated two-channel event counter behind the deser400 test-point mux; results
// are held under a valid/ack handshake. Define DESER400_TP_COINC_EN to add the
// coincidence counter (cnt_ab/ovf_ab).
module deser400_tp_counter
    import deser400_tp_pkg::*;
#(
    parameter int CNT_W  = 16,
    parameter int GATE_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [GATE_W-1:0] gate_len,
    input  logic              tpa,
    input  logic              tpb,
    input  logic              ack,
    output logic              busy,
    output logic              valid,
    output logic [CNT_W-1:0]  cnt_a,
    output logic [CNT_W-1:0]  cnt_b,
    output logic              ovf_a,
`ifdef DESER400_TP_COINC_EN
    output logic [CNT_W-1:0]  cnt_ab,
    output logic              ovf_ab,
`endif
    output logic              ovf_b
);

`ifdef DESER400_TP_COINC_EN
    localparam int NCH = 3;
`else
    localparam int NCH = 2;
`endif

    logic [1:0]        r_state;
    logic [1:0]        r_mode;
    logic [GATE_W-1:0] r_win;
    logic [1:0]        r_prev;
    logic              r_valid;

    logic [1:0]        w_sample;
    logic [1:0]        w_evt;
    logic [NCH-1:0]    w_lane_evt;
    logic [CNT_W-1:0]  w_cnt [NCH];
    logic [NCH-1:0]    w_ovf;
    logic              w_start_go;
    logic              w_count_en;

    assign w_sample   = {tpb, tpa};
    assign w_start_go = (r_state == IDLE) && start;
    // A zero-length window still spends one cycle in COUNT but never counts.
    assign w_count_en = (r_state == COUNT) && (r_win != '0);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_prev <= 2'b00;
        end else begin
            r_prev <= w_sample;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_qual
            tp_event_qual u_qual (
                .i_sample (w_sample[gi]),
                .i_prev   (r_prev[gi]),
                .i_mode   (r_mode),
                .o_event  (w_evt[gi])
            );
        end
    endgenerate

    assign w_lane_evt[1:0] = w_evt;
`ifdef DESER400_TP_COINC_EN
    assign w_lane_evt[2] = &w_evt;
`endif

    // Saturating counter per lane; overflow is sticky until the next start.
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_lane
            logic [CNT_W-1:0] r_cnt;
            logic             r_ovf;

            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    r_cnt <= '0;
                    r_ovf <= 1'b0;
                end else if (w_start_go) begin
                    r_cnt <= '0;
                    r_ovf <= 1'b0;
                end else if (w_count_en && w_lane_evt[gi]) begin
                    if (&r_cnt) begin
                        r_ovf <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
            end

            assign w_cnt[gi] = r_cnt;
            assign w_ovf[gi] = r_ovf;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_mode  <= 2'b00;
            r_win   <= '0;
            r_valid <= 1'b0;
        end else begin
            // valid trails entry into DONE by one edge and drops with ack
            r_valid <= (r_state == DONE) && !ack;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= COUNT;
                        r_mode  <= mode;
                        r_win   <= gate_len;
                    end
                end
                COUNT: begin
                    if (r_win != '0) begin
                        r_win <= r_win - GATE_W'(1);
                    end
                    if (r_win <= GATE_W'(1)) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (ack) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy  = (r_state != IDLE);
    assign valid = r_valid;
    assign cnt_a = w_cnt[0];
    assign cnt_b = w_cnt[1];
    assign ovf_a = w_ovf[0];
    assign ovf_b = w_ovf[1];
`ifdef DESER400_TP_COINC_EN
    assign cnt_ab = w_cnt[2];
    assign ovf_ab = w_ovf[2];
`endif

endmodule

// File: tb/tb_deser400_tp_counter.sv
// Bench for deser400_tp_counter: directed scenarios plus a randomized free run,
// all checked every cycle against an edge-indexed measurement model.
module tb_deser400_tp_counter;

    localparam int CNT_W  = 6;
    localparam int GATE_W = 8;
    localparam int MAXC   = (1 << CNT_W) - 1;
    localparam int HIST   = 16384;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic [1:0]        mode = 2'd0;
    logic [GATE_W-1:0] gate_len = '0;
    logic              tpa = 1'b0;
    logic              tpb = 1'b0;
    logic              ack = 1'b0;
    logic              busy;
    logic              valid;
    logic [CNT_W-1:0]  cnt_a;
    logic [CNT_W-1:0]  cnt_b;
    logic              ovf_a;
    logic              ovf_b;
`ifdef DESER400_TP_COINC_EN
    logic [CNT_W-1:0]  cnt_ab;
    logic              ovf_ab;
`endif

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    int pat  = 0;
    bit hold_a = 1'b0;
    bit hold_b = 1'b0;
    int dens = 50;

    deser400_tp_counter #(
        .CNT_W  (CNT_W),
        .GATE_W (GATE_W)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .mode     (mode),
        .gate_len (gate_len),
        .tpa      (tpa),
        .tpb      (tpb),
        .ack      (ack),
        .busy     (busy),
        .valid    (valid),
        .cnt_a    (cnt_a),
        .cnt_b    (cnt_b),
        .ovf_a    (ovf_a),
`ifdef DESER400_TP_COINC_EN
        .cnt_ab   (cnt_ab),
        .ovf_ab   (ovf_ab),
`endif
        .ovf_b    (ovf_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Test-point waveform generator, changes inputs away from the sampling edge
    always @(negedge clk) begin
        case (pat)
            0: begin tpa = hold_a; tpb = hold_b; end
            1: begin tpa = ~tpa; tpb = 1'b0; end
            2: begin tpa = ~tpa; tpb = tpa; end
            3: begin tpa = ~tpa; tpb = ~tpa; end
            default: begin
                tpa = ($urandom_range(99) < dens);
                tpb = ($urandom_range(99) < dens);
            end
        endcase
    end

    // Reference model: remembers every sampled test-point value by edge number
    // and derives the result of a measurement directly from that history.
    bit hist_a [HIST];
    bit hist_b [HIST];
    bit m_meas = 0, m_busy = 0, m_valid = 0, m_known = 0;
    int m_t = 0, m_n = 0, m_done = 0;
    bit [1:0] m_mode = 0;
    int e_a = 0, e_b = 0, e_ab = 0;
    bit o_a = 0, o_b = 0, o_ab = 0;

    function automatic bit qual(input bit [1:0] m, input bit x, input bit p);
        case (m)
            2'd0:    return x & ~p;
            2'd1:    return ~x & p;
            2'd2:    return x ^ p;
            default: return x;
        endcase
    endfunction

    function automatic void compute();
        int ca = 0, cb = 0, cab = 0;
        for (int j = m_t + 1; j <= m_t + m_n; j++) begin
            bit qa, qb;
            qa = qual(m_mode, hist_a[j], hist_a[j-1]);
            qb = qual(m_mode, hist_b[j], hist_b[j-1]);
            ca += int'(qa);
            cb += int'(qb);
            cab += int'(qa & qb);
        end
        e_a  = (ca  > MAXC) ? MAXC : ca;   o_a  = (ca  > MAXC);
        e_b  = (cb  > MAXC) ? MAXC : cb;   o_b  = (cb  > MAXC);
        e_ab = (cab > MAXC) ? MAXC : cab;  o_ab = (cab > MAXC);
    endfunction

    always @(posedge clk) begin
        if (cyc < HIST) begin
            hist_a[cyc] = tpa;
            hist_b[cyc] = tpb;
        end
        if (!reset_n) begin
            m_meas = 0; m_known = 1;
            e_a = 0; e_b = 0; e_ab = 0; o_a = 0; o_b = 0; o_ab = 0;
        end else if (m_meas) begin
            if (cyc > m_done && ack) begin
                m_meas = 0; m_known = 0;
            end else if (cyc == m_done + 1) begin
                compute();
                m_known = 1;
            end
        end else if (start) begin
            m_meas = 1; m_known = 0;
            m_t = cyc; m_n = int'(gate_len); m_mode = mode;
            m_done = cyc + ((gate_len == 0) ? 1 : int'(gate_len));
        end
        m_busy  = m_meas;
        m_valid = m_meas && (cyc >= m_done + 1);
        cyc++;
    end

    always @(negedge clk) begin
        chk("busy", 32'(busy), 32'(m_busy));
        chk("valid", 32'(valid), 32'(m_valid));
        if (m_known) begin
            chk("cnt_a", 32'(cnt_a), e_a);
            chk("cnt_b", 32'(cnt_b), e_b);
            chk("ovf_a", 32'(ovf_a), 32'(o_a));
            chk("ovf_b", 32'(ovf_b), 32'(o_b));
`ifdef DESER400_TP_COINC_EN
            chk("cnt_ab", 32'(cnt_ab), e_ab);
            chk("ovf_ab", 32'(ovf_ab), 32'(o_ab));
`endif
        end
    end

    task automatic pulse_start(input logic [1:0] m, input int g);
        @(negedge clk);
        start = 1'b1; mode = m; gate_len = GATE_W'(g);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output int lat);
        lat = 0;
        while (valid !== 1'b1 && lat < budget) begin
            @(negedge clk);
            lat++;
        end
        chk("valid_seen", 32'(valid), 32'd1);
    endtask

    task automatic do_ack();
        @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        chk("ack_valid_low", 32'(valid), 32'd0);
        chk("ack_busy_low", 32'(busy), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_cnt_a", 32'(cnt_a), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // rising edges, tpa toggling every cycle
        pat = 1;
        pulse_start(2'd0, 100);
        wait_valid(200, lat);
        chk("t1_latency", lat, 32'd101);
        chk("t1_cnt_a", 32'(cnt_a), 32'd50);
        chk("t1_cnt_b", 32'(cnt_b), 32'd0);
        chk("t1_ovf_a", 32'(ovf_a), 32'd0);
        do_ack();

        // saturation on high-level counting, then cleared by the next start
        pat = 0; hold_a = 1'b1; hold_b = 1'b0;
        repeat (2) @(negedge clk);
        pulse_start(2'd3, 80);
        wait_valid(200, lat);
        chk("sat_cnt_a", 32'(cnt_a), 32'(MAXC));
        chk("sat_ovf_a", 32'(ovf_a), 32'd1);
        chk("sat_cnt_b", 32'(cnt_b), 32'd0);
        do_ack();
        pulse_start(2'd0, 5);
        wait_valid(50, lat);
        chk("clr_latency", lat, 32'd6);
        chk("clr_cnt_a", 32'(cnt_a), 32'd0);
        chk("clr_ovf_a", 32'(ovf_a), 32'd0);
        do_ack();

        // zero-length window with edges present
        pat = 1;
        pulse_start(2'd2, 0);
        wait_valid(50, lat);
        chk("z_latency", lat, 32'd2);
        chk("z_cnt_a", 32'(cnt_a), 32'd0);
        chk("z_cnt_b", 32'(cnt_b), 32'd0);
        do_ack();

        // handshake: stray starts ignored, ack wins over start in DONE
        pat = 4; dens = 50;
        pulse_start(2'd1, 20);
        repeat (5) @(negedge clk);
        pulse_start(2'd3, 3);
        wait_valid(100, lat);
        pulse_start(2'd0, 7);
        chk("hs_valid_hold", 32'(valid), 32'd1);
        chk("hs_busy_hold", 32'(busy), 32'd1);
        @(negedge clk);
        ack = 1'b1; start = 1'b1; mode = 2'd0; gate_len = GATE_W'(5);
        @(negedge clk);
        ack = 1'b0; start = 1'b0;
        chk("hs_busy_drop", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        chk("hs_no_restart", 32'(busy), 32'd0);
        chk("hs_valid_low", 32'(valid), 32'd0);

        // abort by reset mid-window, then a clean measurement
        pulse_start(2'd2, 50);
        repeat (10) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        chk("ab_busy", 32'(busy), 32'd0);
        chk("ab_valid", 32'(valid), 32'd0);
        chk("ab_cnt_a", 32'(cnt_a), 32'd0);
        chk("ab_cnt_b", 32'(cnt_b), 32'd0);
        pat = 1;
        pulse_start(2'd0, 10);
        wait_valid(50, lat);
        chk("ab_re_cnt_a", 32'(cnt_a), 32'd5);
        chk("ab_re_cnt_b", 32'(cnt_b), 32'd0);
        do_ack();

`ifdef DESER400_TP_COINC_EN
        pat = 2;
        pulse_start(2'd2, 10);
        wait_valid(50, lat);
        chk("co_cnt_a", 32'(cnt_a), 32'd10);
        chk("co_cnt_b", 32'(cnt_b), 32'd10);
        chk("co_cnt_ab", 32'(cnt_ab), 32'd10);
        do_ack();
        pat = 3;
        pulse_start(2'd2, 10);
        wait_valid(50, lat);
        chk("coinv_both_ab", 32'(cnt_ab), 32'd10);
        do_ack();
        pulse_start(2'd0, 10);
        wait_valid(50, lat);
        chk("coinv_rise_a", 32'(cnt_a), 32'd5);
        chk("coinv_rise_ab", 32'(cnt_ab), 32'd0);
        do_ack();
`endif

        // randomized free run: every input random, model checks each cycle
        pat = 4;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (i % 200 == 0) dens = $urandom_range(95, 5);
            start    = ($urandom_range(9) == 0);
            ack      = ($urandom_range(5) == 0);
            mode     = 2'($urandom_range(3));
            gate_len = GATE_W'($urandom_range(120));
            reset_n  = !($urandom_range(599) == 0);
        end
        @(negedge clk);
        start = 1'b0; ack = 1'b0; reset_n = 1'b1;
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/deser400_tp_counter.md
# deser400_tp_counter

Gated event counter sitting directly downstream of the deser400 test-point multiplexer. It takes the two selected test-point bits (tpa, tpb) and, on command, counts qualifying events on each over a programmable window of clk cycles. It then holds the results for readout under a valid/ack handshake. This turns the scope-style test-point outputs into numbers readable over the register bus, for rate checks without a scope.

## Interface
- CNT_W, 16: width of each event counter
- GATE_W, 16: width of the window length in clk cycles

- clk  in  1  system clock; all logic on posedge
- reset_n  in  1  synchronous reset, active low
- start  in  1  one-cycle pulse that arms a measurement
- mode  in  2  event qualifier: 0 rising edge, 1 falling edge, 2 both edges, 3 high-level cycles
- gate_len  in  GATE_W  window length in clk cycles
- tpa  in  1  test point A, already registered in the clk domain
- tpb  in  1  test point B, already registered in the clk domain
- ack  in  1  consumer acknowledge; clears valid
- busy  out  1  high in COUNT and DONE
- valid  out  1  results held and readable
- cnt_a  out  CNT_W  event count, channel A
- cnt_b  out  CNT_W  event count, channel B
- ovf_a  out  1  channel A counter saturated
- ovf_b  out  1  channel B counter saturated

## Operation
- Reset value of every output and internal register is 0; the FSM resets to IDLE.
- Previous-sample registers for tpa and tpb update every cycle in every state, so an edge on the first window cycle is detected against the cycle before.
- Event definitions, where x is the current sample and p the previous sample:
  - rising = x & ~p
  - falling = ~x & p
  - both = x ^ p
  - high-level = x
- FSM states and transitions:
  - IDLE: on start, latch mode and gate_len, clear counts and overflow flags, load the window counter with gate_len, go to COUNT.
  - COUNT: each cycle, add 1 to each channel that has a qualifying event and decrement the window counter. Go to DONE on the cycle the window counter reaches 0.
  - DONE: valid=1 and outputs frozen. On ack, go to IDLE.
- gate_len = 0: COUNT lasts one cycle, counts nothing, and DONE follows with zero counts.
- Counters saturate at all-ones and never wrap. The ovf flag is set on the first event that would exceed the maximum and is sticky until the next start.
- start in COUNT or DONE is ignored.
- start and ack together in DONE: ack is honoured, start is dropped.
- ack outside DONE is ignored.
- mode and gate_len changes after start have no effect on the running measurement.
- reset_n low mid-measurement aborts immediately to IDLE with all outputs 0.

## Timing
- Window: with start sampled at edge t, samples at edges t+1 … t+gate_len are evaluated.
- busy rises after edge t.
- valid rises after edge t+gate_len+1 (gate_len ≥ 1), or after edge t+2 for gate_len = 0.
- valid falls after the edge at which ack is sampled high; busy falls on the same edge.
- A new start is accepted one cycle after ack, at the earliest.
- cnt_a, cnt_b, ovf_a and ovf_b are registered and stable throughout valid.

## Configuration
- DESER400_TP_COINC_EN defined:
  - adds output cnt_ab (CNT_W) and ovf_ab.
  - cnt_ab counts cycles where both channels qualify in the same cycle, with the same saturation, reset and hold rules as cnt_a and cnt_b.
- DESER400_TP_COINC_EN not defined: these ports and their logic do not exist; all other behaviour is identical.

## Structure
- Package deser400_tp_pkg holds:
  - mode encodings: TP_RISE, TP_FALL, TP_BOTH, TP_HIGH
  - FSM state encodings: IDLE, COUNT, DONE
- Sub-module tp_event_qual takes one sample and its previous-sample register, plus mode, and outputs a 1-bit event strobe. It is instantiated once per channel.
- The saturating counter is inline RTL, not a separate module.

## Test plan
- Rising edges: mode=0, gate_len=100, tpa toggling every cycle, tpb held 0 → after 101 cycles valid=1, cnt_a=50, cnt_b=0, no overflow.
- Saturation: CNT_W=4, mode=3, gate_len=40, tpa=1 → cnt_a=15, ovf_a=1; the next start clears both.
- Zero-length window: gate_len=0 with edges present → valid 2 cycles after start, all counts 0.
- Handshake: start pulses during COUNT and DONE are ignored. With ack and start together in DONE, the FSM returns to IDLE, busy=0, and no new measurement begins.
- Abort: reset_n=0 in the middle of COUNT → next cycle all outputs 0 and state IDLE; a fresh start then measures correctly.
- Coincidence (DESER400_TP_COINC_EN): tpa and tpb both toggling in phase, mode=2, gate_len=10 → cnt_a=cnt_b=cnt_ab=10. With tpb inverted, cnt_ab=10 under mode=2 and 0 under mode=0.
